// File: rtl/video_pkg.sv
// Shared video-pipeline constants: border-mode encodings and default frame geometry.
// Latency: n/a (constants only).
// Backpressure: n/a.
package video_pkg;

  // Fill rows above the frame top with zeros.
  localparam int BORDER_ZERO = 0;
  // Fill rows above the frame top with a copy of frame row 0.
  localparam int BORDER_REPL = 1;

  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;

endpackage

// File: rtl/lb_row_ram.sv
// One line of pixel storage: simple dual-port RAM with one write port and a registered read port.
// Latency: read data appears 1 cycle after i_re; a same-address write in that cycle returns old data.
// Backpressure: none; the read register holds its value while i_re is low.
module lb_row_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 640,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  (* ramstyle = "M10K" *) logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_q;

  // Write port plus registered read; non-blocking update gives read-before-write.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_q <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/window_line_buffer.sv
// Line buffer emitting a KSIZE-tall pixel column (current row + KSIZE-1 rows above) per input pixel.
// Latency: 1 cycle from in_valid to out_valid; top-of-frame rows masked per BORDER_MODE.
// Backpressure: none; idle cycles hold counters and output data, out_valid drops.
module window_line_buffer
  import video_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int IMG_W       = IMG_W_DEF,
  parameter int IMG_H       = IMG_H_DEF,
  parameter int KSIZE       = 5,
  parameter int BORDER_MODE = BORDER_ZERO,
  parameter int X_W         = $clog2(IMG_W),
  parameter int Y_W         = $clog2(IMG_H)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_sof,
  output logic                    out_valid,
  output logic [KSIZE*DATA_W-1:0] out_col,
  output logic [X_W-1:0]          out_x,
  output logic [Y_W-1:0]          out_y,
  output logic                    out_sof,
  output logic                    out_eol
);

  localparam int SEL_W = $clog2(KSIZE);

  logic [X_W-1:0]    r_x, w_x, r_out_x;
  logic [Y_W-1:0]    r_y, w_y, r_out_y;
  logic              w_last_x, w_last_y;
  logic [KSIZE-1:1]  w_miss, r_zero, r_repl;
  logic [SEL_W-1:0]  w_ysel, r_ysel;
  logic              r_vld, r_sof, r_eol;
  logic [DATA_W-1:0] r_tap0;
  logic [DATA_W-1:0] w_rd   [KSIZE-1];
  logic [DATA_W-1:0] w_src  [KSIZE];
  logic [DATA_W-1:0] w_repl;

  // Effective position of the incoming pixel (in_sof overrides the counters) and border flags.
  always_comb begin
    w_x      = in_sof ? '0 : r_x;
    w_y      = in_sof ? '0 : r_y;
    w_last_x = (w_x == X_W'(IMG_W - 1));
    w_last_y = (w_y == Y_W'(IMG_H - 1));
    w_ysel   = (int'(w_y) >= KSIZE - 1) ? SEL_W'(KSIZE - 1) : SEL_W'(w_y);
    w_miss   = '0;
    for (int k = 1; k < KSIZE; k++) begin
      w_miss[k] = (k > int'(w_y));
    end
  end

  // Raster position counters: advance per accepted pixel, wrap at line and frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (in_valid) begin
      if (w_last_x) begin
        r_x <= '0;
        r_y <= w_last_y ? '0 : w_y + 1'b1;
      end else begin
        r_x <= w_x + 1'b1;
        r_y <= w_y;
      end
    end
  end

  // Output-side registers: tap 0, coordinates, flags and per-tap border selects for the accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld   <= 1'b0;
      r_tap0  <= '0;
      r_out_x <= '0;
      r_out_y <= '0;
      r_sof   <= 1'b0;
      r_eol   <= 1'b0;
      r_zero  <= '1;
      r_repl  <= '0;
      r_ysel  <= '0;
    end else begin
      r_vld <= in_valid;
      if (in_valid) begin
        r_tap0  <= in_data;
        r_out_x <= w_x;
        r_out_y <= w_y;
        r_sof   <= (w_x == '0) && (w_y == '0);
        r_eol   <= w_last_x;
        r_zero  <= (BORDER_MODE == BORDER_ZERO) ? w_miss : '0;
        r_repl  <= (BORDER_MODE == BORDER_REPL) ? w_miss : '0;
        r_ysel  <= w_ysel;
      end
    end
  end

  // Row memories: read at the pixel's x, then written one cycle later with the column just
  // presented, so memory j receives memory j-1's pre-write contents at that x.
  for (genvar j = 0; j < KSIZE - 1; j++) begin : g_row
    lb_row_ram #(
      .DATA_W(DATA_W),
      .DEPTH (IMG_W),
      .AW    (X_W)
    ) u_ram (
      .clk     (clk),
      .i_we    (r_vld),
      .i_waddr (r_out_x),
      .i_wdata (w_src[j]),
      .i_re    (in_valid),
      .i_raddr (w_x),
      .o_rdata (w_rd[j])
    );
  end

  // Assemble the output column, substituting zeros or row 0 for taps above the frame top.
  always_comb begin
    w_src[0] = r_tap0;
    for (int k = 1; k < KSIZE; k++) begin
      w_src[k] = w_rd[k-1];
    end
    w_repl  = w_src[r_ysel];
    out_col = '0;
    out_col[DATA_W-1:0] = r_tap0;
    for (int k = 1; k < KSIZE; k++) begin
      if (r_zero[k]) begin
        out_col[k*DATA_W +: DATA_W] = '0;
      end else if (r_repl[k]) begin
        out_col[k*DATA_W +: DATA_W] = w_repl;
      end else begin
        out_col[k*DATA_W +: DATA_W] = w_src[k];
      end
    end
  end

  assign out_valid = r_vld;
  assign out_x     = r_out_x;
  assign out_y     = r_out_y;
  assign out_sof   = r_sof;
  assign out_eol   = r_eol;

endmodule

// File: tb/tb_window_line_buffer.sv
// Self-checking bench: two instances (zero-pad and replicate) on a 4x4 frame with KSIZE=3.
// Expected columns come from a frame-image model indexed by (row, x).
// Scenarios: smoke, valid gaps, mid-frame restart, frame wrap, async reset, random soak.
module tb_window_line_buffer;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int K  = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_sof;

  logic          vld0, vld1, sof0, sof1, eol0, eol1;
  logic [K*DW-1:0] col0, col1;
  logic [1:0]    x0, x1, y0, y1;

  window_line_buffer #(
    .DATA_W(DW), .IMG_W(W), .IMG_H(H), .KSIZE(K), .BORDER_MODE(0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
    .out_valid(vld0), .out_col(col0), .out_x(x0), .out_y(y0), .out_sof(sof0), .out_eol(eol0)
  );

  window_line_buffer #(
    .DATA_W(DW), .IMG_W(W), .IMG_H(H), .KSIZE(K), .BORDER_MODE(1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
    .out_valid(vld1), .out_col(col1), .out_x(x1), .out_y(y1), .out_sof(sof1), .out_eol(eol1)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_eol = 0;

  // Reference model state: raster position of the next pixel and the current frame image.
  int            mx, my;
  logic [DW-1:0] img [0:H-1][0:W-1];
  logic [K*DW-1:0] e0, e1;
  int            ex, ey;
  logic          esof, eeol;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mx = 0; my = 0;
    e0 = '0; e1 = '0;
    ex = 0; ey = 0;
  endtask

  // One clock: drive at the falling edge, predict, check 1 ns after the rising edge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic s);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    in_sof   = v & s;
    if (v) begin
      if (s) begin mx = 0; my = 0; end
      img[my][mx] = d;
      for (int k = 0; k < K; k++) begin
        e0[k*DW +: DW] = (k > my) ? '0 : img[my-k][mx];
        e1[k*DW +: DW] = (k > my) ? img[0][mx] : img[my-k][mx];
      end
      ex = mx; ey = my;
      esof = (mx == 0) && (my == 0);
      eeol = (mx == W - 1);
      if (mx == W - 1) begin
        mx = 0;
        my = (my == H - 1) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
    end
    @(posedge clk);
    #1;
    chk("valid0", 32'(vld0), 32'(v));
    chk("valid1", 32'(vld1), 32'(v));
    chk("col0", 32'(col0), 32'(e0));
    chk("col1", 32'(col1), 32'(e1));
    chk("out_x", 32'(x0), 32'(ex));
    chk("out_y", 32'(y0), 32'(ey));
    if (v) begin
      chk("out_sof", 32'(sof0), 32'(esof));
      chk("out_eol", 32'(eol0), 32'(eeol));
      if (vld0 && eol0) n_eol++;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_sof   = 1'b0;
    model_reset();
    #12;
    chk("rst_valid", 32'(vld0), 32'd0);
    chk("rst_col0", 32'(col0), 32'd0);
    chk("rst_col1", 32'(col1), 32'd0);
    chk("rst_xy", 32'({x0, y0}), 32'd0);
    chk("rst_flags", 32'({sof0, eol0}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Smoke: pixels 1..16, directed taps at (1,0), (3,1), (2,2).
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 8'(i), i == 1);
      if (i == 2) begin
        chk("smoke_z_1_0", 32'(col0), 32'h000002);
        chk("smoke_r_1_0", 32'(col1), 32'h020202);
      end
      if (i == 8)  chk("smoke_r_3_1", 32'(col1), 32'h040408);
      if (i == 11) chk("smoke_z_2_2", 32'(col0), 32'h03070B);
    end

    // Valid gaps: same stream with random bubbles; hold behaviour checked in every idle step.
    for (int i = 1; i <= 16; i++) begin
      while ($urandom_range(0, 2) == 0) step(1'b0, 8'($urandom), 1'b0);
      step(1'b1, 8'(i), i == 1);
      if (i == 11) chk("gap_z_2_2", 32'(col0), 32'h03070B);
    end

    // Mid-frame restart at (2,1).
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'($urandom), (i == 0) || (i == 6));
      if (i == 6) begin
        chk("restart_sof", 32'(sof0), 32'd1);
        chk("restart_xy", 32'({x0, y0}), 32'd0);
        chk("restart_upper", 32'(col0[K*DW-1:DW]), 32'd0);
      end
    end

    // Frame wrap: two frames, only the first pixel carries in_sof.
    n_eol = 0;
    for (int i = 0; i < 2 * W * H; i++) begin
      step(1'b1, 8'($urandom), i == 0);
      if (i == W * H) begin
        chk("wrap_sof", 32'(sof0), 32'd1);
        chk("wrap_xy", 32'({x0, y0}), 32'd0);
      end
    end
    chk("wrap_eol_count", 32'(n_eol), 32'(2 * H));

    // Async reset mid-line, between clock edges.
    step(1'b1, 8'($urandom), 1'b1);
    step(1'b1, 8'($urandom), 1'b0);
    step(1'b1, 8'($urandom), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'({vld0, vld1}), 32'd0);
    chk("arst_col0", 32'(col0), 32'd0);
    chk("arst_col1", 32'(col1), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    model_reset();
    rst_n = 1'b1;
    step(1'b1, 8'($urandom), 1'b0);
    chk("arst_next_xy", 32'({x0, y0}), 32'd0);
    chk("arst_next_sof", 32'(sof0), 32'd1);

    // Random soak: random valid and occasional restarts.
    for (int i = 0; i < 400; i++) begin
      logic v;
      v = ($urandom_range(0, 3) != 0);
      step(v, 8'($urandom), v && ($urandom_range(0, 49) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
